// File: rtl/shift_seq_unit_if.sv
// Request/response bundle between the ALU issue logic and shift_seq_unit.
//   start  : request valid, sampled only while ready=1
//   op     : 0 SLL, 1 SRL, 2 SRA, 3 ROL, 4 ROR, 5-7 illegal
//   d, s   : operand and shift amount, sampled with start
//   ready  : sequencer idle and able to accept start
//   y      : result register, holds the last completed result
//   done   : one-cycle pulse, y valid in that cycle
//   err    : one-cycle pulse alongside done for an illegal op
interface shift_seq_unit_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] d;
  logic [31:0] s;
  logic        ready;
  logic [31:0] y;
  logic        done;
  logic        err;

  modport master (output start, op, d, s, input ready, y, done, err);
  modport slave  (input start, op, d, s, output ready, y, done, err);
endinterface

// File: rtl/shift_seq_unit.sv
// shift_seq_unit: multi-cycle shift sequencer wrapped around a single
// combinational 32-bit shifter (SHIFT32). Logical shifts take one pass.
// SRA, ROL and ROR take two passes whose results are OR-combined.
//   clk   : clock, rising-edge
//   rst_n : asynchronous active-low reset
//   bus   : shift_seq_unit_if.slave (start/op/d/s in, ready/y/done/err out)
//
// SHIFT32: Y = D shifted by S; LnR=1 shifts left; S >= 32 yields 0.

module SHIFT32 (
  output logic [31:0] Y,
  input  logic [31:0] D,
  input  logic [31:0] S,
  input  logic        LnR
);
  always_comb begin
    if (S >= 32'd32)  Y = '0;
    else if (LnR)     Y = D << S[4:0];
    else              Y = D >> S[4:0];
  end
endmodule

module shift_seq_unit (
  input  logic           clk,
  input  logic           rst_n,
  shift_seq_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, P1, P2, FIN} state_t;

  localparam logic [2:0] OP_SLL = 3'd0;
  localparam logic [2:0] OP_SRL = 3'd1;
  localparam logic [2:0] OP_SRA = 3'd2;
  localparam logic [2:0] OP_ROL = 3'd3;
  localparam logic [2:0] OP_ROR = 3'd4;

  state_t      state, state_nx;
  logic [31:0] d_r, s_r, acc, acc_nx, y_r;
  logic [2:0]  op_r;
  logic        flag, flag_nx;
  logic        done_r, err_r;

  logic [31:0] sh_d, sh_s, sh_y;
  logic        sh_lnr;
  logic [5:0]  rot_amt;

  SHIFT32 u_shift (.Y(sh_y), .D(sh_d), .S(sh_s), .LnR(sh_lnr));

  // Complementary amount for the second rotate pass. An amount of 0 gives 32,
  // so the second pass contributes nothing and the rotate returns D.
  assign rot_amt = 6'd32 - {1'b0, s_r[4:0]};

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    flag_nx  = flag;
    sh_d     = d_r;
    sh_s     = s_r;
    sh_lnr   = 1'b0;
    case (state)
      IDLE: if (bus.start) state_nx = P1;
      P1: begin
        case (op_r)
          OP_SLL: begin sh_lnr = 1'b1; acc_nx = sh_y; state_nx = FIN; end
          OP_SRL: begin acc_nx = sh_y; state_nx = FIN; end
          OP_SRA: begin acc_nx = sh_y; state_nx = P2; end
          OP_ROL: begin
            sh_s = {27'b0, s_r[4:0]}; sh_lnr = 1'b1; acc_nx = sh_y; state_nx = P2;
          end
          OP_ROR: begin
            sh_s = {27'b0, s_r[4:0]}; acc_nx = sh_y; state_nx = P2;
          end
          default: begin acc_nx = '0; flag_nx = 1'b1; state_nx = FIN; end
        endcase
      end
      P2: begin
        state_nx = FIN;
        case (op_r)
          // Second pass shifts all-ones to build the mask of vacated bits;
          // its complement supplies the sign fill.
          OP_SRA: begin
            sh_d   = 32'hFFFF_FFFF;
            acc_nx = acc | (d_r[31] ? ~sh_y : 32'h0);
          end
          OP_ROL: begin
            sh_s = {26'b0, rot_amt}; acc_nx = acc | sh_y;
          end
          OP_ROR: begin
            sh_s = {26'b0, rot_amt}; sh_lnr = 1'b1; acc_nx = acc | sh_y;
          end
          default: acc_nx = acc;
        endcase
      end
      FIN: begin state_nx = IDLE; flag_nx = 1'b0; end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      d_r    <= '0;
      s_r    <= '0;
      op_r   <= '0;
      acc    <= '0;
      flag   <= 1'b0;
      y_r    <= '0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      flag  <= flag_nx;
      if (state == IDLE && bus.start) begin
        d_r  <= bus.d;
        s_r  <= bus.s;
        op_r <= bus.op;
      end
      // Outputs are registered on the FIN entry edge so y, done and err line
      // up in the FIN cycle.
      done_r <= (state_nx == FIN);
      err_r  <= (state_nx == FIN) && flag_nx;
      if (state_nx == FIN) y_r <= acc_nx;
    end
  end

  assign bus.ready = (state == IDLE);
  assign bus.y     = y_r;
  assign bus.done  = done_r;
  assign bus.err   = err_r;
endmodule

// File: tb/tb_shift_seq_unit.sv
module tb_shift_seq_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  shift_seq_unit_if bus ();
  shift_seq_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] y;
    logic        err;
    int          lat;
    int          t0;
    string       name;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_done: got done=1 expected no pulse (y=%h)", bus.y);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_y"}, bus.y, e.y);
          chk({e.name, "_err"}, {31'b0, bus.err}, {31'b0, e.err});
          chk({e.name, "_lat"}, cyc - e.t0 + 1, e.lat);
          @(posedge clk); #1;
          chk({e.name, "_ready_after"}, {31'b0, bus.ready}, 32'd1);
        end
      end else if (bus.err === 1'b1) begin
        n_cmp++; n_bad++;
        $display("FAIL stray_err: got err=1 expected 0 without done");
      end
    end
  end

  task automatic issue(input string name, input logic [2:0] op, input logic [31:0] d,
                       input logic [31:0] s, input logic [31:0] ey, input logic eerr,
                       input int lat, input bit push);
    int k;
    exp_t e;
    k = 0;
    @(negedge clk);
    while (bus.ready !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    if (k >= 20) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_wait_ready: got ready=%b expected 1 within 20 cycles", name, bus.ready);
    end
    bus.start = 1'b1; bus.op = op; bus.d = d; bus.s = s;
    @(posedge clk); #1;
    bus.start = 1'b0;
    // Scramble inputs while busy: must not affect the result.
    bus.d = ~d; bus.s = s + 32'd7; bus.op = op ^ 3'd1;
    if (push) begin
      e.y = ey; e.err = eerr; e.lat = lat; e.t0 = cyc; e.name = name;
      sb.push_back(e);
    end
    chk({name, "_busy"}, {31'b0, bus.ready}, 32'd0);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((sb.size() != 0 || bus.ready !== 1'b1) && k < 50) begin @(negedge clk); k++; end
    if (k >= 50) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: got %0d outstanding expected 0", sb.size());
    end
  endtask

  initial begin
    exp_t e;
    bus.start = 1'b0; bus.op = '0; bus.d = '0; bus.s = '0;
    #12;
    chk("rst_y", bus.y, 32'h0);
    chk("rst_ready", {31'b0, bus.ready}, 32'd1);
    chk("rst_done", {31'b0, bus.done}, 32'd0);
    chk("rst_err", {31'b0, bus.err}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // First SLL: explicit ready/done timing checks.
    issue("sll_f1", 3'd0, 32'h0000_00F1, 32'd4, 32'h0000_0F10, 1'b0, 2, 1);
    @(posedge clk); #1;
    chk("sll_f1_busy2", {31'b0, bus.ready}, 32'd0);
    chk("sll_f1_done_cyc", {31'b0, bus.done}, 32'd1);
    drain();

    issue("sra_a",   3'd2, 32'h8000_0010, 32'd4,  32'hF800_0001, 1'b0, 3, 1);
    issue("sra_s40n",3'd2, 32'h8000_0000, 32'd40, 32'hFFFF_FFFF, 1'b0, 3, 1);
    issue("sra_s40p",3'd2, 32'h7000_0000, 32'd40, 32'h0000_0000, 1'b0, 3, 1);
    issue("sra_s0",  3'd2, 32'h8234_5678, 32'd0,  32'h8234_5678, 1'b0, 3, 1);
    issue("rol_1",   3'd3, 32'h8000_0001, 32'd1,  32'h0000_0003, 1'b0, 3, 1);
    issue("ror_1",   3'd4, 32'h8000_0001, 32'd1,  32'hC000_0000, 1'b0, 3, 1);
    issue("rol_32",  3'd3, 32'h8000_0001, 32'd32, 32'h8000_0001, 1'b0, 3, 1);
    issue("ror_33",  3'd4, 32'h8000_0001, 32'd33, 32'hC000_0000, 1'b0, 3, 1);
    issue("ill_6",   3'd6, 32'h1234_5678, 32'd3,  32'h0000_0000, 1'b1, 2, 1);
    issue("srl_f0",  3'd1, 32'h0000_00F0, 32'd4,  32'h0000_000F, 1'b0, 2, 1);
    issue("sll_s32", 3'd0, 32'h0000_0001, 32'd32, 32'h0000_0000, 1'b0, 2, 1);
    issue("srl_s31", 3'd1, 32'hFFFF_FFFF, 32'd31, 32'h0000_0001, 1'b0, 2, 1);
    issue("ror_8",   3'd4, 32'h1234_5678, 32'd8,  32'h7812_3456, 1'b0, 3, 1);
    drain();

    // start held high: SRL by 0 accepted every third edge, d changes each cycle.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd1; bus.s = 32'd0;
    for (int i = 0; i < 9; i++) begin
      bus.d = 32'h100 + i;
      @(posedge clk); #1;
      if (i % 3 == 0) begin
        e.y = 32'h100 + i; e.err = 1'b0; e.lat = 2; e.t0 = cyc; e.name = "held";
        sb.push_back(e);
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    drain();

    // Reset during P2 of a ROR.
    issue("ror_abort", 3'd4, 32'h8000_0001, 32'd1, 32'h0, 1'b0, 3, 0);
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    chk("abort_y", bus.y, 32'h0);
    chk("abort_ready", {31'b0, bus.ready}, 32'd1);
    chk("abort_done", {31'b0, bus.done}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    issue("sll_post", 3'd0, 32'h0000_0003, 32'd2, 32'h0000_000C, 1'b0, 2, 1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/shift_seq_unit.md
Name: shift_seq_unit

Overview:
- Multi-cycle shift sequencer upstream of the combinational 32-bit shifter SHIFT32.
- It registers an operation request, then drives one shared SHIFT32 instance for one or two passes. Ports on that instance: Y, D, S, LnR; LnR=1 means left shift; S >= 32 yields 0.
- Combines the passes into logical shift, arithmetic right shift and rotate results.
- Sits between the ALU issue logic and the ALU result mux. It gives the ALU SRA/ROL/ROR without a second shifter.

Parameters:
- None. Width is fixed at 32 to match SHIFT32.

Ports:
- CLK  input  1  clock; all state updates on rising edge
- RST  input  1  asynchronous, active-low reset
- START  input  1  request valid; sampled only when READY=1
- OP  input  3  operation: 0 SLL, 1 SRL, 2 SRA, 3 ROL, 4 ROR, 5-7 illegal
- D  input  32  operand, sampled with START
- S  input  32  shift amount, sampled with START
- READY  output  1  high when idle and able to accept START
- Y  output  32  result register; holds last completed result
- DONE  output  1  one-cycle pulse; Y is valid in that cycle
- ERR  output  1  one-cycle pulse alongside DONE for illegal OP

Behaviour:
- Reset (RST=0, asynchronous): state=IDLE, Y=0, DONE=0, ERR=0, internal operand/amount/accumulator registers=0. READY=1 while in reset.
- States: IDLE, P1, P2, FIN.
- READY = (state==IDLE), decoded from state.
- IDLE:
  - START=1 at an edge latches D, S, OP into internal regs and moves to P1.
  - START=0: stay.
- P1: shifter inputs by op; edge captures shifter output into ACC.
  - SLL: D_r, S_r, LnR=1. Next FIN.
  - SRL: D_r, S_r, LnR=0. Next FIN.
  - SRA: D_r, S_r, LnR=0. Next P2.
  - ROL: D_r, {27'b0,S_r[4:0]}, LnR=1. Next P2.
  - ROR: D_r, {27'b0,S_r[4:0]}, LnR=0. Next P2.
  - Illegal: ACC<=0, ERR flag set. Next FIN.
- P2 (second pass):
  - SRA:
    - Shifter input 32'hFFFFFFFF, S_r, LnR=0, giving MASK.
    - ACC <= ACC | (D_r[31] ? ~MASK : 0).
  - ROL:
    - Shifter input D_r, amount 32 - S_r[4:0] (6-bit result, zero-extended), LnR=0.
    - ACC <= ACC | shifter output.
  - ROR: same as ROL, with LnR=1.
  - Next FIN.
- FIN:
  - Y <= ACC.
  - DONE=1 and ERR=flag for this cycle only. DONE and ERR are registered outputs, asserted in the cycle after the last capture edge.
  - Next edge returns to IDLE and clears the ERR flag.
- Latency, START edge to the cycle where DONE=1:
  - SLL/SRL/illegal: 2 cycles.
  - SRA/ROL/ROR: 3 cycles.
  - Throughput: one op per 3 or 4 cycles; the IDLE cycle is mandatory.
- START while READY=0 is ignored; the request is not queued. D/S/OP changes while busy have no effect.
- Boundary rules:
  - SLL/SRL with S >= 32 give 0.
  - SRA with S >= 32 gives all bits = D[31].
  - SRA with S=0 gives D.
  - Rotates use S[4:0] only. Amount 0 gives D, because the second pass has amount 32 and yields 0.
- Y changes only on the FIN entry edge or on reset.
- Reset asserted mid-operation aborts immediately to IDLE. No DONE pulse; Y=0.

Test Plan:
- Reset, then SLL D=32'h0000_00F1 S=4: READY=0 for 2 cycles. DONE pulses with Y=32'h0000_0F10, ERR=0. READY back to 1 the next cycle.
- SRA D=32'h8000_0010 S=4: DONE 3 cycles after START, Y=32'hF800_0001. SRA D=32'h8000_0000 S=40: Y=32'hFFFF_FFFF. SRA D=32'h7000_0000 S=40: Y=0.
- ROL D=32'h8000_0001 S=1: Y=32'h0000_0003. ROR same D, S=1: Y=32'hC000_0000. ROL S=32 (S[4:0]=0): Y=D. ROR S=33: Y as for S=1.
- Illegal OP=6: DONE and ERR both pulse 2 cycles after START, Y=0. The next legal SRL D=32'hF0 S=4 gives Y=32'h0F, ERR=0.
- START held high continuously with changing D:
  - Only requests sampled in IDLE complete.
  - Mid-op D changes do not alter the result.
  - Exactly one DONE per accepted request.
- Assert RST during P2 of a ROR: Y=0, DONE never pulses, READY=1 immediately. After release, a new SLL completes normally.
